// File: rtl/fetch_pc_unit.sv
// -----------------------------------------------------------------------------
// fetch_pc_unit
//   Instruction-fetch stage. Owns the PC, issues single-cycle instruction
//   memory requests and fills the IF/ID pipeline register. Redirects (jr,
//   jump, taken branch) come back from decode. A one-entry skid buffer keeps
//   an instruction that was acknowledged during a decode stall, so it is
//   never fetched a second time.
//
// Ports
//   clk, rst_n                 clock / asynchronous active-low reset
//   jr_control, jr_target      jr redirect and its register-file target
//   jump, jump_target          absolute jump redirect
//   branch_taken, branch_offset taken branch, signed offset from ifid_pc_plus1
//   stall                      IF/ID must hold this cycle
//   imem_req, imem_addr        fetch request / address (always equal to pc)
//   imem_ack, imem_rdata       same-cycle response and instruction
//   pc                         current program counter
//   ifid_valid, ifid_instr, ifid_pc_plus1   IF/ID register contents
// -----------------------------------------------------------------------------
module fetch_pc_unit #(
    parameter int                 ADDR_W   = 16,
    parameter int                 INSTR_W  = 16,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                jr_control,
    input  logic [ADDR_W-1:0]   jr_target,
    input  logic                jump,
    input  logic [ADDR_W-1:0]   jump_target,
    input  logic                branch_taken,
    input  logic [ADDR_W-1:0]   branch_offset,
    input  logic                stall,
    output logic                imem_req,
    output logic [ADDR_W-1:0]   imem_addr,
    input  logic                imem_ack,
    input  logic [INSTR_W-1:0]  imem_rdata,
    output logic [ADDR_W-1:0]   pc,
    output logic                ifid_valid,
    output logic [INSTR_W-1:0]  ifid_instr,
    output logic [ADDR_W-1:0]   ifid_pc_plus1
);

    localparam logic [1:0] ST_BOOT  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [1:0]          state;
    logic [INSTR_W-1:0]  skid_instr;
    logic [ADDR_W-1:0]   skid_pc1;
    logic [ADDR_W-1:0]   pc_inc;
    logic                redirect;
    logic [ADDR_W-1:0]   target;

    assign imem_req  = (state == ST_FETCH);
    assign imem_addr = pc;
    // Wraps to zero at all-ones.
    assign pc_inc    = pc + ONE;

    // Redirect controls only mean something when decode actually holds a live
    // instruction and is allowed to advance.
    assign redirect = ifid_valid & ~stall & (jr_control | jump | branch_taken);

    // Two's-complement add gives the signed branch offset for free; the
    // result is modulo 2^ADDR_W.
    always_comb begin
        target = ifid_pc_plus1 + branch_offset;
        if (jr_control)
            target = jr_target;
        else if (jump)
            target = jump_target;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_BOOT;
            pc            <= RESET_PC;
            ifid_valid    <= 1'b0;
            ifid_instr    <= '0;
            ifid_pc_plus1 <= '0;
            skid_instr    <= '0;
            skid_pc1      <= '0;
        end else begin
            case (state)
                ST_BOOT: begin
                    state <= ST_FETCH;
                end

                ST_FETCH: begin
                    if (redirect) begin
                        // Any ack this cycle is a wrong-path fetch: drop it.
                        pc         <= target;
                        ifid_valid <= 1'b0;
                    end else if (stall && imem_ack) begin
                        // IF/ID is busy; park the acked instruction so it is
                        // not requested again after the stall.
                        skid_instr <= imem_rdata;
                        skid_pc1   <= pc_inc;
                        state      <= ST_HOLD;
                    end else if (!stall && imem_ack) begin
                        ifid_valid    <= 1'b1;
                        ifid_instr    <= imem_rdata;
                        ifid_pc_plus1 <= pc_inc;
                        pc            <= pc_inc;
                    end else if (!stall) begin
                        ifid_valid <= 1'b0;
                    end
                end

                ST_HOLD: begin
                    if (!stall) begin
                        state <= ST_FETCH;
                        if (redirect) begin
                            pc         <= target;
                            ifid_valid <= 1'b0;
                        end else begin
                            ifid_valid    <= 1'b1;
                            ifid_instr    <= skid_instr;
                            ifid_pc_plus1 <= skid_pc1;
                            pc            <= skid_pc1;
                        end
                    end
                end

                default: begin
                    state <= ST_BOOT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_pc_unit
//   Directed bench for fetch_pc_unit. The instruction memory returns
//   addr ^ 16'hA5A5, so every expected instruction below is a hand-computed
//   constant tied to its fetch address.
// -----------------------------------------------------------------------------
module tb_fetch_pc_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        jr_control;
    logic [15:0] jr_target;
    logic        jump;
    logic [15:0] jump_target;
    logic        branch_taken;
    logic [15:0] branch_offset;
    logic        stall;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic [15:0] pc;
    logic        ifid_valid;
    logic [15:0] ifid_instr;
    logic [15:0] ifid_pc_plus1;

    int n_assert = 0;
    int n_fail   = 0;

    fetch_pc_unit #(.ADDR_W(16), .INSTR_W(16), .RESET_PC(16'h0000)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .jr_control    (jr_control),
        .jr_target     (jr_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .stall         (stall),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .pc            (pc),
        .ifid_valid    (ifid_valid),
        .ifid_instr    (ifid_instr),
        .ifid_pc_plus1 (ifid_pc_plus1)
    );

    always #5 clk = ~clk;

    assign imem_rdata = imem_addr ^ 16'hA5A5;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ifid(input string tag, input logic v, input logic [15:0] ins,
                            input logic [15:0] p1);
        chk({tag, "_valid"}, {31'd0, ifid_valid}, {31'd0, v});
        chk({tag, "_instr"}, {16'd0, ifid_instr}, {16'd0, ins});
        chk({tag, "_pc1"},   {16'd0, ifid_pc_plus1}, {16'd0, p1});
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_pc"},  {16'd0, pc}, 32'h0);
        chk({tag, "_req"}, {31'd0, imem_req}, 32'h0);
        chk_ifid(tag, 1'b0, 16'h0000, 16'h0000);
    endtask

    initial begin
        rst_n = 1'b0; jr_control = 1'b0; jr_target = '0; jump = 1'b0;
        jump_target = '0; branch_taken = 1'b0; branch_offset = '0;
        stall = 1'b0; imem_ack = 1'b1;

        // ---- 1: reset, boot, sequential fetch
        tick(); tick();
        chk_reset("rst");
        rst_n = 1'b1;
        chk("boot_req", {31'd0, imem_req}, 32'h0);
        chk("boot_pc", {16'd0, pc}, 32'h0);
        tick();                                    // BOOT -> FETCH
        chk("fetch_req", {31'd0, imem_req}, 32'h1);
        chk("fetch_valid0", {31'd0, ifid_valid}, 32'h0);
        tick();
        chk_ifid("seq0", 1'b1, 16'hA5A5, 16'h0001);
        tick();
        chk_ifid("seq1", 1'b1, 16'hA5A4, 16'h0002);
        tick();
        chk_ifid("seq2", 1'b1, 16'hA5A7, 16'h0003);
        chk("seq_pc", {16'd0, pc}, 32'h3);

        // ---- 2: jr redirect
        jr_control = 1'b1; jr_target = 16'h0040;
        tick();
        jr_control = 1'b0;
        chk("jr_addr", {16'd0, imem_addr}, 32'h40);
        chk("jr_flush", {31'd0, ifid_valid}, 32'h0);
        tick();
        chk_ifid("jr_fetch", 1'b1, 16'hA5E5, 16'h0041);

        // ---- 3: priority jr > jump > branch, then backward branch
        jr_control = 1'b1; jr_target = 16'h000F;
        jump = 1'b1; jump_target = 16'h0200;
        branch_taken = 1'b1; branch_offset = 16'h0100;
        tick();
        jr_control = 1'b0; jump = 1'b0; branch_taken = 1'b0;
        chk("prio_pc", {16'd0, pc}, 32'hF);
        tick();
        chk_ifid("prio_fetch", 1'b1, 16'hA5AA, 16'h0010);
        branch_taken = 1'b1; branch_offset = 16'hFFFC;
        tick();
        chk("br_pc", {16'd0, pc}, 32'hC);
        chk("br_flush", {31'd0, ifid_valid}, 32'h0);
        tick();                                    // branch_taken ignored: IF/ID was empty
        branch_taken = 1'b0;
        chk("br_ignored_pc", {16'd0, pc}, 32'hD);
        chk_ifid("br_fetch", 1'b1, 16'hA5A9, 16'h000D);

        // ---- 4: stall with ack at pc=5 -> HOLD, then release
        jump = 1'b1; jump_target = 16'h0004;
        tick();
        jump = 1'b0;
        tick();
        chk("pre_stall_pc", {16'd0, pc}, 32'h5);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_req", {31'd0, imem_req}, 32'h0);
            chk("hold_pc", {16'd0, pc}, 32'h5);
            chk_ifid("hold", 1'b1, 16'hA5A1, 16'h0005);
        end
        stall = 1'b0;
        tick();
        chk_ifid("skid_out", 1'b1, 16'hA5A0, 16'h0006);
        chk("skid_addr", {16'd0, imem_addr}, 32'h6);
        chk("skid_req", {31'd0, imem_req}, 32'h1);
        tick();
        chk_ifid("after_skid", 1'b1, 16'hA5A3, 16'h0007);

        // ---- 5: pc wrap, then bubble on missing ack
        jump = 1'b1; jump_target = 16'hFFFF;
        tick();
        jump = 1'b0;
        chk("wrap_pre", {16'd0, imem_addr}, 32'hFFFF);
        tick();
        chk_ifid("wrap", 1'b1, 16'h5A5A, 16'h0000);
        chk("wrap_addr", {16'd0, imem_addr}, 32'h0);
        imem_ack = 1'b0;
        tick();
        chk("bubble_valid", {31'd0, ifid_valid}, 32'h0);
        chk("bubble_pc", {16'd0, pc}, 32'h0);
        tick();
        chk("bubble_pc2", {16'd0, pc}, 32'h0);
        imem_ack = 1'b1;

        // ---- 6a: reset in the middle of HOLD
        tick();
        chk_ifid("pre_hold", 1'b1, 16'hA5A5, 16'h0001);
        stall = 1'b1;
        tick();                                    // skid now holds instr@1
        chk("in_hold_req", {31'd0, imem_req}, 32'h0);
        #2 rst_n = 1'b0;
        #1 chk_reset("rst_hold");
        stall = 1'b0;
        tick();
        chk_reset("rst_hold_edge");
        rst_n = 1'b1;
        tick();                                    // BOOT -> FETCH
        chk_ifid("post_rst_h", 1'b0, 16'h0000, 16'h0000);
        tick();
        chk_ifid("post_rst_h_fetch", 1'b1, 16'hA5A5, 16'h0001);

        // ---- 6b: reset in the middle of a redirect
        jr_control = 1'b1; jr_target = 16'h0077;
        #3 rst_n = 1'b0;
        #1 chk_reset("rst_redir");
        tick();
        chk_reset("rst_redir_edge");
        jr_control = 1'b0;
        rst_n = 1'b1;
        tick();
        chk("post_rst_r_addr", {16'd0, imem_addr}, 32'h0);
        chk("post_rst_r_req", {31'd0, imem_req}, 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
